vga_line_drawer: RTL and testbench
==================================

# vga_line_drawer

Bresenham line-drawing engine that acts as the pixel producer for the VGA adapter's user write port. On a start pulse it latches two endpoints and a colour, then emits one pixel write per clock (x, y, color, plot) along the line until the second endpoint is written. It sits between user draw logic and the adapter. Its outputs wire directly to the adapter's x/y/color/plot inputs on the same 50 MHz clock.

## Interface
- BITS_PER_CHANNEL, 5, bits per colour channel
- WIDTH, 336, visible pixels per row (1680/5)
- HEIGHT, 210, visible rows (1050/5)
- WIDTH2, $clog2(WIDTH), x coordinate width
- HEIGHT2, $clog2(HEIGHT), y coordinate width

- clk50  in  1  50 MHz board clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  pulse to begin a line; sampled only in IDLE
- i_x0, i_x1  in  WIDTH2  start and end x
- i_y0, i_y1  in  HEIGHT2  start and end y
- i_color  in  [2:0][BITS_PER_CHANNEL-1:0]  line colour
- o_busy  out  1  high in DRAW
- o_done  out  1  one-cycle pulse after the last pixel
- o_x  out  WIDTH2  pixel x to the adapter
- o_y  out  HEIGHT2  pixel y to the adapter
- o_color  out  [2:0][BITS_PER_CHANNEL-1:0]  pixel colour
- o_plot  out  1  write strobe to the adapter

## Operation
- States: IDLE, DRAW, DONE.
- Reset (async, reset_n=0): state=IDLE. o_busy=0, o_done=0, o_plot=0, o_x=0, o_y=0, o_color=0. Internal err/dx/dy are cleared.
- IDLE with i_start=1: the block latches the endpoints and colour and sets x=x0, y=y0.
  - dx=|x1-x0|, dy=-|y1-y0|, err=dx+dy.
  - sx=+1 if x0<x1, else -1. sy=+1 if y0<y1, else -1.
  - Next state is DRAW.
- IDLE with i_start=0: the block stays in IDLE.
- DRAW, every cycle: o_plot=1 with o_x=x and o_y=y.
  - If x==x1 and y==y1, next state is DONE.
  - Otherwise, e2=2*err. If e2>=dy: err+=dy and x+=sx. If e2<=dx: err+=dx and y+=sy. Both updates apply in the same cycle when both conditions hold.
- DONE: o_done=1 and o_plot=0 for one cycle. Next state is IDLE.
- i_start is ignored in DRAW and DONE; the latched endpoints are never changed mid-line.
- Clipping: a pixel with x>=WIDTH or y>=HEIGHT drives o_plot=0 for that cycle. Stepping continues, so the cycle count is unchanged.
- Arithmetic: dx, dy and err are signed, with width max(WIDTH2,HEIGHT2)+2. e2 is one bit wider. No overflow is possible for any legal input.
- Degenerate line (x0==x1, y0==y1): exactly one pixel, then DONE.

## Timing
- Start sampled at edge N. The first pixel is presented in cycle N+1, with o_busy=1.
- Pixel count P=max(|x1-x0|,|y1-y0|)+1. Exactly one pixel is presented per cycle, with no stalls.
- The last pixel is in cycle N+P. o_done=1 in cycle N+P+1, and o_busy=0 from that cycle.
- The earliest next accepted i_start is at edge N+P+2, i.e. while in IDLE.
- o_x, o_y, o_color and o_busy are registered. o_plot is the registered state decode ANDed with a clip compare of the registered x and y.
- reset_n asserted mid-line: outputs return to their reset values immediately, without waiting for a clock edge. No further o_plot or o_done is produced.

## Test plan
- **Horizontal line:** (0,0)->(4,0), color={31,0,0} -> o_plot high for 5 consecutive cycles with x=0,1,2,3,4 and y=0. o_done follows 1 cycle later, and o_busy is high for exactly 5 cycles.
- **Shallow line:** (0,0)->(4,2) -> pixels (0,0),(1,1),(2,1),(3,2),(4,2) in order, then o_done.
- **Reverse diagonal:** (3,3)->(0,0) -> pixels (3,3),(2,2),(1,1),(0,0). Repeat with steep (5,0)->(5,3) -> x fixed at 5, y=0..3.
- **Single point:** (10,20)->(10,20) -> exactly one o_plot at (10,20), o_done the next cycle.
- **Clipping:** (334,0)->(338,0) with WIDTH=336 -> 5 DRAW cycles. o_plot is high only for x=334 and x=335, and o_done occurs at cycle N+6.
- **Robustness:**
  - Pulse i_start with new endpoints during DRAW -> ignored, and the original line completes unchanged.
  - Assert reset_n=0 mid-line -> o_plot=0 and o_busy=0 immediately.
  - After release, a new start -> a correct full line.

Source files
------------

// File: rtl/vga_line_drawer.sv
// Bresenham line engine: latches two endpoints and a colour on i_start, then
// emits one pixel write per clock to the VGA adapter until the far endpoint.
module vga_line_drawer #(
    parameter int BITS_PER_CHANNEL = 5,
    parameter int WIDTH            = 336,
    parameter int HEIGHT           = 210,
    parameter int WIDTH2           = $clog2(WIDTH),
    parameter int HEIGHT2          = $clog2(HEIGHT)
) (
    input  logic                                  clk50,
    input  logic                                  reset_n,
    input  logic                                  i_start,
    input  logic [WIDTH2-1:0]                     i_x0,
    input  logic [WIDTH2-1:0]                     i_x1,
    input  logic [HEIGHT2-1:0]                    i_y0,
    input  logic [HEIGHT2-1:0]                    i_y1,
    input  logic [2:0][BITS_PER_CHANNEL-1:0]      i_color,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [WIDTH2-1:0]                     o_x,
    output logic [HEIGHT2-1:0]                    o_y,
    output logic [2:0][BITS_PER_CHANNEL-1:0]      o_color,
    output logic                                  o_plot
);

    localparam int CW = ((WIDTH2 > HEIGHT2) ? WIDTH2 : HEIGHT2) + 2;
    localparam int EW = CW + 1;
    localparam logic signed [CW-1:0] ZERO  = '0;
    localparam logic [WIDTH2:0]      X_LIM = (WIDTH2 + 1)'(WIDTH);
    localparam logic [HEIGHT2:0]     Y_LIM = (HEIGHT2 + 1)'(HEIGHT);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t                           state_reg;
    logic [WIDTH2-1:0]                x_reg;
    logic [WIDTH2-1:0]                x1_reg;
    logic [HEIGHT2-1:0]               y_reg;
    logic [HEIGHT2-1:0]               y1_reg;
    logic [2:0][BITS_PER_CHANNEL-1:0] color_reg;
    logic signed [CW-1:0]             dx_reg;
    logic signed [CW-1:0]             dy_reg;
    logic signed [CW-1:0]             err_reg;
    logic                             sx_reg;
    logic                             sy_reg;
    logic                             busy_reg;
    logic                             done_reg;

    // Start-time deltas: dx is |x1-x0|, dy is stored already negated.
    logic signed [CW-1:0] x0_s, x1_s, y0_s, y1_s;
    logic signed [CW-1:0] dx_start, dy_start;

    always_comb begin
        x0_s     = $signed(CW'(i_x0));
        x1_s     = $signed(CW'(i_x1));
        y0_s     = $signed(CW'(i_y0));
        y1_s     = $signed(CW'(i_y1));
        dx_start = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
        dy_start = (y1_s >= y0_s) ? (y0_s - y1_s) : (y1_s - y0_s);
    end

    logic signed [EW-1:0]   e2, dx_e, dy_e;
    logic                   step_x, step_y, at_end;
    logic signed [CW-1:0]   err_next;
    logic [WIDTH2-1:0]      x_next;
    logic [HEIGHT2-1:0]     y_next;

    always_comb begin
        e2       = {err_reg, 1'b0};
        dx_e     = {dx_reg[CW-1], dx_reg};
        dy_e     = {dy_reg[CW-1], dy_reg};
        step_x   = (e2 >= dy_e);
        step_y   = (e2 <= dx_e);
        err_next = err_reg + (step_x ? dy_reg : ZERO) + (step_y ? dx_reg : ZERO);
        x_next   = x_reg;
        y_next   = y_reg;
        if (step_x)
            x_next = x_reg + (sx_reg ? WIDTH2'(1) : {WIDTH2{1'b1}});
        if (step_y)
            y_next = y_reg + (sy_reg ? HEIGHT2'(1) : {HEIGHT2{1'b1}});
        at_end   = (x_reg == x1_reg) && (y_reg == y1_reg);
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            x1_reg    <= '0;
            y_reg     <= '0;
            y1_reg    <= '0;
            color_reg <= '0;
            dx_reg    <= '0;
            dy_reg    <= '0;
            err_reg   <= '0;
            sx_reg    <= 1'b0;
            sy_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (i_start) begin
                        x_reg     <= i_x0;
                        y_reg     <= i_y0;
                        x1_reg    <= i_x1;
                        y1_reg    <= i_y1;
                        color_reg <= i_color;
                        dx_reg    <= dx_start;
                        dy_reg    <= dy_start;
                        err_reg   <= dx_start + dy_start;
                        sx_reg    <= (i_x0 < i_x1);
                        sy_reg    <= (i_y0 < i_y1);
                        busy_reg  <= 1'b1;
                        state_reg <= DRAW;
                    end
                end
                DRAW: begin
                    // The endpoint pixel is the one on screen now; stop without stepping.
                    if (at_end) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        x_reg   <= x_next;
                        y_reg   <= y_next;
                        err_reg <= err_next;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_x     = x_reg;
    assign o_y     = y_reg;
    assign o_color = color_reg;
    assign o_busy  = busy_reg;
    assign o_done  = done_reg;
    // Off-screen pixels still take a cycle but are not written.
    assign o_plot  = (state_reg == DRAW) && ({1'b0, x_reg} < X_LIM) && ({1'b0, y_reg} < Y_LIM);

endmodule

// File: tb/tb_vga_line_drawer.sv
// Self-checking bench for vga_line_drawer: directed and random lines compared
// against an integer Bresenham reference with clipping.
module tb_vga_line_drawer;

    localparam int BPC    = 5;
    localparam int WIDTH  = 336;
    localparam int HEIGHT = 210;
    localparam int W2     = 9;
    localparam int H2     = 8;

    logic                    clk50 = 1'b0;
    logic                    reset_n;
    logic                    i_start;
    logic [W2-1:0]           i_x0, i_x1;
    logic [H2-1:0]           i_y0, i_y1;
    logic [2:0][BPC-1:0]     i_color;
    logic                    o_busy, o_done, o_plot;
    logic [W2-1:0]           o_x;
    logic [H2-1:0]           o_y;
    logic [2:0][BPC-1:0]     o_color;

    int tests  = 0;
    int failed = 0;
    int exp_x[$];
    int exp_y[$];

    always #10 clk50 = ~clk50;

    vga_line_drawer #(
        .BITS_PER_CHANNEL(BPC),
        .WIDTH(WIDTH),
        .HEIGHT(HEIGHT)
    ) dut (
        .clk50(clk50),
        .reset_n(reset_n),
        .i_start(i_start),
        .i_x0(i_x0),
        .i_x1(i_x1),
        .i_y0(i_y0),
        .i_y1(i_y1),
        .i_color(i_color),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_x(o_x),
        .o_y(o_y),
        .o_color(o_color),
        .o_plot(o_plot)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference pixel sequence from the textbook integer Bresenham loop.
    task automatic build_ref(input int x0, input int y0, input int x1, input int y1);
        int x, y, dx, dy, err, sx, sy, e2;
        x   = x0;
        y   = y0;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
        err = dx + dy;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        exp_x.delete();
        exp_y.delete();
        for (int k = 0; k < 2048; k++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [14:0] col, input bit glitch);
        int n;
        logic on_screen;
        build_ref(x0, y0, x1, y1);
        n = exp_x.size();
        @(negedge clk50);
        i_x0    = W2'(x0);
        i_y0    = H2'(y0);
        i_x1    = W2'(x1);
        i_y1    = H2'(y1);
        i_color = col;
        i_start = 1'b1;
        @(posedge clk50);
        #1;
        i_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (glitch && k == 1) begin
                i_start = 1'b1;
                i_x0    = W2'($urandom_range(0, 300));
                i_x1    = W2'($urandom_range(0, 300));
                i_y0    = H2'($urandom_range(0, 200));
                i_y1    = H2'($urandom_range(0, 200));
                i_color = 15'($urandom);
            end
            if (glitch && k == 2) i_start = 1'b0;
            on_screen = (exp_x[k] < WIDTH) && (exp_y[k] < HEIGHT);
            check("busy",  32'(o_busy),  32'd1);
            check("done",  32'(o_done),  32'd0);
            check("x",     32'(o_x),     exp_x[k]);
            check("y",     32'(o_y),     exp_y[k]);
            check("plot",  32'(o_plot),  32'(on_screen));
            check("color", 32'(o_color), 32'(col));
            @(posedge clk50);
            #1;
        end
        i_start = 1'b0;
        check("done_pulse", 32'(o_done), 32'd1);
        check("busy_end",   32'(o_busy), 32'd0);
        check("plot_end",   32'(o_plot), 32'd0);
        @(posedge clk50);
        #1;
        check("done_clear", 32'(o_done), 32'd0);
        check("idle_plot",  32'(o_plot), 32'd0);
        $display("[TB] line (%0d,%0d)->(%0d,%0d) color=%h pixels=%0d", x0, y0, x1, y1, col, n);
    endtask

    initial begin
        reset_n = 1'b0;
        i_start = 1'b0;
        i_x0    = '0;
        i_x1    = '0;
        i_y0    = '0;
        i_y1    = '0;
        i_color = '0;
        #5;
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        check("rst_plot",  32'(o_plot),  32'd0);
        check("rst_x",     32'(o_x),     32'd0);
        check("rst_y",     32'(o_y),     32'd0);
        check("rst_color", 32'(o_color), 32'd0);
        @(negedge clk50);
        reset_n = 1'b1;
        repeat (2) @(negedge clk50);

        run_line(0, 0, 4, 0, 15'h7C00, 1'b0);
        run_line(0, 0, 4, 2, 15'h03E0, 1'b0);
        run_line(3, 3, 0, 0, 15'h001F, 1'b0);
        run_line(5, 0, 5, 3, 15'h1234, 1'b0);
        run_line(10, 20, 10, 20, 15'h7FFF, 1'b0);
        run_line(334, 0, 338, 0, 15'h5555, 1'b0);
        run_line(300, 205, 340, 215, 15'h2AAA, 1'b0);
        run_line(20, 10, 60, 30, 15'h0F0F, 1'b1);

        // Reset in the middle of a line must silence the outputs at once.
        @(negedge clk50);
        i_x0 = W2'(0); i_y0 = H2'(0); i_x1 = W2'(50); i_y1 = H2'(10);
        i_color = 15'h3C3C;
        i_start = 1'b1;
        @(posedge clk50);
        #1;
        i_start = 1'b0;
        repeat (3) @(posedge clk50);
        #5;
        reset_n = 1'b0;
        #1;
        check("mid_rst_plot",  32'(o_plot),  32'd0);
        check("mid_rst_busy",  32'(o_busy),  32'd0);
        check("mid_rst_done",  32'(o_done),  32'd0);
        check("mid_rst_x",     32'(o_x),     32'd0);
        check("mid_rst_color", 32'(o_color), 32'd0);
        repeat (3) begin
            @(posedge clk50);
            #1;
            check("held_rst_plot", 32'(o_plot), 32'd0);
            check("held_rst_done", 32'(o_done), 32'd0);
        end
        @(negedge clk50);
        reset_n = 1'b1;
        @(negedge clk50);
        run_line(7, 9, 2, 30, 15'h4321, 1'b0);

        for (int r = 0; r < 25; r++) begin
            run_line(int'($urandom_range(0, 345)), int'($urandom_range(0, 220)),
                     int'($urandom_range(0, 345)), int'($urandom_range(0, 220)),
                     15'($urandom), r[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
